regfile_dumper: RTL and testbench

Debug read-out engine for the CPU register file. On a `start` pulse it requests a CPU stall, then walks the register file's read port over a fixed address range. Each register is emitted as an (address, data) word on a valid/ready stream toward the debug/UART path. It sits beside the datapath, sharing one regfile read port through the top-level debug mux, and releases the stall when the last word is accepted.

---
 rtl/regfile_dumper.sv | 133 +++++++++++++
 tb/tb_regfile_dumper.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_dumper.sv
// Debug read-out engine: stalls the CPU, walks the regfile read port over
// [FIRST_REG, LAST_REG] and streams each (address, data) pair on valid/ready.
module regfile_dumper #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        halt_req,
   output logic [4:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_addr,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        done
);

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_READ   = 3'd2,
      ST_SEND   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [4:0]  idx_r;
   logic        at_last_s;
   logic        send_hs_s;
   logic        busy_r;
   logic        halt_req_r;
   logic        out_valid_r;
   logic [4:0]  out_addr_r;
   logic [31:0] out_data_r;
   logic        out_last_r;
   logic        done_r;

   // The index register doubles as the read address, so it stays valid through READ
   assign at_last_s = (idx_r == LAST_IDX);
   assign send_hs_s = (state_r == ST_SEND) && out_ready;

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_SETTLE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: state_s = ST_READ;
         ST_READ:   state_s = ST_SEND;
         ST_SEND: begin
            if (!out_ready) begin
               state_s = ST_SEND;
            end else if (at_last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_DONE:   state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Status outputs registered from the upcoming state so they align with it
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r     <= 1'b0;
         halt_req_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         busy_r     <= (state_s != ST_IDLE);
         halt_req_r <= (state_s == ST_SETTLE) || (state_s == ST_READ) || (state_s == ST_SEND);
         done_r     <= (state_s == ST_DONE);
      end
   end

   // Index walk and output word capture
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_r       <= FIRST_IDX;
         out_valid_r <= 1'b0;
         out_addr_r  <= 5'd0;
         out_data_r  <= 32'd0;
         out_last_r  <= 1'b0;
      end else begin
         if ((state_r == ST_IDLE) && start) begin
            idx_r <= FIRST_IDX;
         end else if (send_hs_s && !at_last_s) begin
            idx_r <= idx_r + 5'd1;
         end
         if (state_r == ST_READ) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= idx_r;
            out_data_r  <= rf_rdata;
            out_last_r  <= at_last_s;
         end else if (send_hs_s) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign busy      = busy_r;
   assign halt_req  = halt_req_r;
   assign rf_raddr  = idx_r;
   assign out_valid = out_valid_r;
   assign out_addr  = out_addr_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign done      = done_r;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: directed dumps with random data/backpressure,
// checked cycle by cycle against a transaction-level model of the stream.
module tb_regfile_dumper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, out_ready, sel;
   logic [31:0] rf [32];

   logic        busy_a, halt_a, valid_a, last_a, done_a, start_a;
   logic [4:0]  raddr_a, addr_a;
   logic [31:0] rdata_a, data_a;
   logic        busy_b, halt_b, valid_b, last_b, done_b, start_b;
   logic [4:0]  raddr_b, addr_b;
   logic [31:0] rdata_b, data_b;

   logic        m_busy, m_halt, m_valid, m_last, m_done;
   logic [4:0]  m_raddr, m_addr;
   logic [31:0] m_data;

   int errors = 0;
   int checks = 0;

   assign rdata_a = rf[raddr_a];
   assign rdata_b = rf[raddr_b];
   assign start_a = start & ~sel;
   assign start_b = start & sel;

   assign m_busy  = sel ? busy_b  : busy_a;
   assign m_halt  = sel ? halt_b  : halt_a;
   assign m_valid = sel ? valid_b : valid_a;
   assign m_last  = sel ? last_b  : last_a;
   assign m_done  = sel ? done_b  : done_a;
   assign m_raddr = sel ? raddr_b : raddr_a;
   assign m_addr  = sel ? addr_b  : addr_a;
   assign m_data  = sel ? data_b  : data_a;

   regfile_dumper u_a (
      .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .halt_req(halt_a),
      .rf_raddr(raddr_a), .rf_rdata(rdata_a), .out_valid(valid_a), .out_ready(out_ready),
      .out_addr(addr_a), .out_data(data_a), .out_last(last_a), .done(done_a)
   );

   regfile_dumper #(.FIRST_REG(8), .LAST_REG(10)) u_b (
      .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .halt_req(halt_b),
      .rf_raddr(raddr_b), .rf_rdata(rdata_b), .out_valid(valid_b), .out_ready(out_ready),
      .out_addr(addr_b), .out_data(data_b), .out_last(last_b), .done(done_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One dump. The model tracks which word is due and when, derived only from
   // the ready pattern this bench drives: first word valid 3 cycles after start,
   // each accepted word followed by a READ cycle, done one cycle after the last accept.
   task automatic run_dump(input bit use_b, input int first, input int last,
                           input int stall_addr, input int stall_n, input bit rnd,
                           input int restart_at, output int dut_done, output int stalls);
      int cyc, next_valid, last_hs, held, exp_addr;
      bit ev;
      sel = use_b;
      out_ready = 1'b1;
      start = 1'b1;
      cyc = 0; next_valid = 3; last_hs = -1; held = 0; exp_addr = first;
      stalls = 0; dut_done = -1;
      while (!(last_hs >= 0 && cyc >= last_hs + 4) && cyc < 1000) begin
         step();
         cyc++;
         ev = (last_hs < 0) && (cyc >= next_valid);
         chk("busy", 32'(m_busy), 32'(last_hs < 0 || cyc == last_hs + 1));
         chk("halt_req", 32'(m_halt), 32'(last_hs < 0));
         chk("done", 32'(m_done), 32'(last_hs >= 0 && cyc == last_hs + 1));
         chk("out_valid", 32'(m_valid), 32'(ev));
         if (m_done && dut_done < 0) dut_done = cyc;
         if (ev) begin
            chk("out_addr", 32'(m_addr), 32'(exp_addr));
            chk("out_data", m_data, rf[exp_addr]);
            chk("out_last", 32'(m_last), 32'(exp_addr == last));
         end
         if (last_hs < 0 && cyc == next_valid - 1) chk("rf_raddr", 32'(m_raddr), 32'(exp_addr));
         start = (cyc == restart_at) || (restart_at > 0 && last_hs >= 0 && cyc == last_hs + 1);
         if (ev && exp_addr == stall_addr && held < stall_n) begin
            out_ready = 1'b0;
            held++;
         end else if (rnd && ev && $urandom_range(0, 3) == 0) begin
            out_ready = 1'b0;
         end else begin
            out_ready = 1'b1;
         end
         if (ev && !out_ready) stalls++;
         if (ev && out_ready) begin
            if (exp_addr == last) last_hs = cyc;
            else exp_addr++;
            next_valid = cyc + 2;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      chk("dump_bounded", 32'(cyc < 1000), 32'd1);
      chk("done_cycle", 32'(dut_done), 32'(2 * (last - first + 1) + 2 + stalls));
   endtask

   initial begin
      int d, s, k;
      reset = 1'b1; start = 1'b0; out_ready = 1'b1; sel = 1'b0;
      rf[0] = 32'd0;
      for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
      step(); step();
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_halt", 32'(halt_a), 32'd0);
      chk("rst_raddr_a", 32'(raddr_a), 32'd0);
      chk("rst_raddr_b", 32'(raddr_b), 32'd8);
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      reset = 1'b0;
      step();

      // Full dump with ready tied high
      run_dump(1'b0, 0, 31, -1, 0, 1'b0, -1, d, s);
      chk("full_done66", 32'(d), 32'd66);

      // Backpressure on addr 7 with random contents
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      run_dump(1'b0, 0, 31, 7, 4, 1'b0, -1, d, s);
      chk("bp_done70", 32'(d), 32'd70);

      // Subrange instance
      run_dump(1'b1, 8, 10, -1, 0, 1'b0, -1, d, s);
      chk("sub_done8", 32'(d), 32'd8);

      // Start while busy and in the done cycle, with random backpressure
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      run_dump(1'b0, 0, 31, -1, 0, 1'b1, 10, d, s);

      // Reset mid-dump at addr 12
      sel = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (!(valid_a && addr_a == 5'd12) && k < 100) begin
         step();
         k++;
      end
      chk("reach_addr12", 32'(addr_a), 32'd12);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_busy", 32'(busy_a), 32'd0);
      chk("mid_halt", 32'(halt_a), 32'd0);
      chk("mid_raddr", 32'(raddr_a), 32'd0);
      chk("mid_valid", 32'(valid_a), 32'd0);
      chk("mid_addr", 32'(addr_a), 32'd0);
      chk("mid_data", data_a, 32'd0);
      chk("mid_last", 32'(last_a), 32'd0);
      chk("mid_done", 32'(done_a), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_done", 32'(done_a), 32'd0);
         chk("post_rst_busy", 32'(busy_a), 32'd0);
      end
      run_dump(1'b0, 0, 31, -1, 0, 1'b1, -1, d, s);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
